grid_erode_engine: RTL and testbench

//  Parametrised neighbour-count erosion engine for a binary occupancy grid.

---
 rtl/grid_pkg.sv | 19 +
 rtl/grid_row_eval.sv | 47 ++++
 rtl/grid_erode_engine.sv | 163 ++++++++++++++++
 tb/tb_grid_erode_engine.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/grid_pkg.sv
// Shared definitions for the grid engines: controller state encoding and counter sizing.
// Latency: none; this file holds only types and constant functions.
// Backpressure: not applicable.
package grid_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SWEEP,
      CHECK,
      DONE
   } grid_state_t;

   // Bits needed to count every cell of a w x h grid, zero included.
   function automatic int cnt_width(input int w, input int h);
      return $clog2(w * h + 1);
   endfunction

endpackage

// File: rtl/grid_row_eval.sv
// One-row erosion step: keep mask and cleared-cell count from the rows above, at and below.
// Latency: purely combinational.
// Backpressure: none; the caller presents one row triple per cycle.
// Ports:
//   up, mid, dn : original rows r-1, r, r+1 (bit j = column j; off-grid rows are passed as 0)
//   keep        : mid with every cell of fewer than THRESH set neighbours cleared
//   clr_cnt     : number of cells set in mid but cleared in keep
module grid_row_eval #(
   parameter int WIDTH  = 140,
   parameter int THRESH = 4
) (
   input  logic [WIDTH-1:0]             up,
   input  logic [WIDTH-1:0]             mid,
   input  logic [WIDTH-1:0]             dn,
   output logic [WIDTH-1:0]             keep,
   output logic [$clog2(WIDTH+1)-1:0]   clr_cnt
);

   localparam int CW = $clog2(WIDTH + 1);

   // One zero column on each side, so column j of the grid sits at padded index j+1
   // and the left/right edges need no special casing.
   logic [WIDTH+1:0] up_p;
   logic [WIDTH+1:0] mid_p;
   logic [WIDTH+1:0] dn_p;

   assign up_p  = {1'b0, up,  1'b0};
   assign mid_p = {1'b0, mid, 1'b0};
   assign dn_p  = {1'b0, dn,  1'b0};

   genvar j;
   for (j = 0; j < WIDTH; j++) begin : g_cell
      logic [3:0] nbr;
      assign nbr = 4'(up_p[j])  + 4'(up_p[j+1])  + 4'(up_p[j+2])
                 + 4'(mid_p[j])                  + 4'(mid_p[j+2])
                 + 4'(dn_p[j])  + 4'(dn_p[j+1])  + 4'(dn_p[j+2]);
      assign keep[j] = mid[j] && (nbr >= 4'(THRESH));
   end

   always_comb begin
      clr_cnt = '0;
      for (int k = 0; k < WIDTH; k++) begin
         clr_cnt = clr_cnt + CW'(mid[k] & ~keep[k]);
      end
   end

endmodule

// File: rtl/grid_erode_engine.sv
// Neighbour-count erosion of a streamed binary grid, one sweep or repeated to a fixpoint.
// Latency: from the last row handshake to finished = passes*(HEIGHT+1)+1 cycles.
// Backpressure: load_ready is high only in LOAD; gaps in load_valid are tolerated.
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   start, mode            : run request (accepted in IDLE/DONE), 0 = one sweep, 1 = to fixpoint
//   load_valid/ready/row   : row stream, rows 0..HEIGHT-1 in order
//   busy, finished         : LOAD/SWEEP/CHECK, DONE
//   result, passes         : total cells cleared, sweeps performed
//   overflow               : fixpoint run stopped by MAX_PASSES while still clearing
module grid_erode_engine
   import grid_pkg::*;
#(
   parameter int WIDTH      = 140,
   parameter int HEIGHT     = 140,
   parameter int THRESH     = 4,
   parameter int MAX_PASSES = 255
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 start,
   input  logic                                 mode,
   input  logic                                 load_valid,
   output logic                                 load_ready,
   input  logic [WIDTH-1:0]                     load_row,
   output logic                                 busy,
   output logic                                 finished,
   output logic [cnt_width(WIDTH, HEIGHT)-1:0]  result,
   output logic [$clog2(MAX_PASSES+1)-1:0]      passes,
   output logic                                 overflow
);

   localparam int CNT_W  = cnt_width(WIDTH, HEIGHT);
   localparam int PASS_W = $clog2(MAX_PASSES + 1);
   localparam int ROW_W  = $clog2(HEIGHT);
   localparam int RC_W   = $clog2(WIDTH + 1);
   localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(HEIGHT - 1);
   localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(MAX_PASSES - 1);

   grid_state_t state;
   grid_state_t state_nxt;

   logic [WIDTH-1:0] grid [HEIGHT];
   logic [ROW_W-1:0] row;
   logic [ROW_W-1:0] dn_idx;
   logic [WIDTH-1:0] prev_row;
   logic [WIDTH-1:0] up_row;
   logic [WIDTH-1:0] mid_row;
   logic [WIDTH-1:0] dn_row;
   logic [WIDTH-1:0] keep;
   logic [RC_W-1:0]  row_clr;
   logic [CNT_W-1:0] sweep_clr;
   logic             mode_q;
   logic             start_ok;
   logic             load_fire;
   logic             last_row;
   logic             sweep_stop;

   assign start_ok   = start && (state == IDLE || state == DONE);
   assign load_fire  = load_valid && load_ready;
   assign last_row   = (row == LAST_ROW);
   assign sweep_stop = !mode_q || (sweep_clr == '0) || (passes == LAST_PASS);

   // Row r is rewritten in place, so the upper neighbour must come from prev_row,
   // which holds the unmodified copy of row r-1. Row r+1 is still original in storage.
   assign dn_idx  = last_row ? row : row + ROW_W'(1);
   assign mid_row = grid[row];
   assign up_row  = (row == '0) ? '0 : prev_row;
   assign dn_row  = last_row ? '0 : grid[dn_idx];

   grid_row_eval #(
      .WIDTH  (WIDTH),
      .THRESH (THRESH)
   ) u_row_eval (
      .up      (up_row),
      .mid     (mid_row),
      .dn      (dn_row),
      .keep    (keep),
      .clr_cnt (row_clr)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: if (start) state_nxt = LOAD;
         LOAD:       if (load_fire && last_row) state_nxt = SWEEP;
         SWEEP:      if (last_row) state_nxt = CHECK;
         CHECK:      state_nxt = sweep_stop ? DONE : SWEEP;
         default:    state_nxt = IDLE;
      endcase
   end

   // State-decoded outputs
   always_comb begin
      load_ready = (state == LOAD);
      busy       = (state == LOAD) || (state == SWEEP) || (state == CHECK);
      finished   = (state == DONE);
   end

   // Row storage has no reset; every run reloads it before sweeping.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (load_fire) begin
            grid[row] <= load_row;
         end else if (state == SWEEP) begin
            grid[row] <= mid_row & keep;
         end
      end
   end

   // Row pointer, counters and run flags
   always_ff @(posedge clk) begin
      if (rst) begin
         row       <= '0;
         prev_row  <= '0;
         mode_q    <= 1'b0;
         sweep_clr <= '0;
         result    <= '0;
         passes    <= '0;
         overflow  <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start_ok) begin
                  row       <= '0;
                  mode_q    <= mode;
                  sweep_clr <= '0;
                  result    <= '0;
                  passes    <= '0;
                  overflow  <= 1'b0;
               end
            end
            LOAD: begin
               if (load_fire) row <= last_row ? '0 : row + ROW_W'(1);
            end
            SWEEP: begin
               prev_row  <= mid_row;
               sweep_clr <= sweep_clr + CNT_W'(row_clr);
               result    <= result + CNT_W'(row_clr);
               row       <= last_row ? '0 : row + ROW_W'(1);
            end
            CHECK: begin
               passes    <= passes + PASS_W'(1);
               sweep_clr <= '0;
               // Only a fixpoint run that is cut off while still clearing is an overflow.
               if (mode_q && sweep_clr != '0 && passes == LAST_PASS) overflow <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_grid_erode_engine.sv
// Bench for grid_erode_engine on a 4x4 grid, THRESH=4, with MAX_PASSES=255 (dut_a) and 2 (dut_b)
// driven in parallel: directed table, random grids against a cell-level model, and a reset
// in the middle of a sweep.
module tb_grid_erode_engine;

   localparam int W = 4;
   localparam int H = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       start;
   logic       mode;
   logic       load_valid;
   logic [3:0] load_row;

   logic       load_ready_a, busy_a, finished_a, overflow_a;
   logic [4:0] result_a;
   logic [7:0] passes_a;
   logic       load_ready_b, busy_b, finished_b, overflow_b;
   logic [4:0] result_b;
   logic [1:0] passes_b;

   grid_erode_engine #(.WIDTH(W), .HEIGHT(H), .THRESH(4), .MAX_PASSES(255)) dut_a (
      .clk(clk), .rst(rst), .start(start), .mode(mode),
      .load_valid(load_valid), .load_ready(load_ready_a), .load_row(load_row),
      .busy(busy_a), .finished(finished_a), .result(result_a),
      .passes(passes_a), .overflow(overflow_a)
   );

   grid_erode_engine #(.WIDTH(W), .HEIGHT(H), .THRESH(4), .MAX_PASSES(2)) dut_b (
      .clk(clk), .rst(rst), .start(start), .mode(mode),
      .load_valid(load_valid), .load_ready(load_ready_b), .load_row(load_row),
      .busy(busy_b), .finished(finished_b), .result(result_b),
      .passes(passes_b), .overflow(overflow_b)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Whole-grid reference: bit r*W+c is cell (r,c). Every sweep reads the pre-sweep grid.
   function automatic void model(input logic [15:0] g0, input bit m, input int maxp,
                                 output int res, output int pas, output bit ovf,
                                 output logic [15:0] gf);
      logic [15:0] g;
      logic [15:0] ng;
      int clr;
      int n;
      g   = g0;
      res = 0;
      pas = 0;
      ovf = 1'b0;
      for (int p = 0; p < 1000; p++) begin
         ng  = g;
         clr = 0;
         for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
               if (g[r*W+c]) begin
                  n = 0;
                  for (int dr = -1; dr <= 1; dr++) begin
                     for (int dc = -1; dc <= 1; dc++) begin
                        if ((dr != 0 || dc != 0) && r+dr >= 0 && r+dr < H &&
                            c+dc >= 0 && c+dc < W) begin
                           if (g[(r+dr)*W+c+dc]) n++;
                        end
                     end
                  end
                  if (n < 4) begin
                     ng[r*W+c] = 1'b0;
                     clr++;
                  end
               end
            end
         end
         g   = ng;
         res += clr;
         pas++;
         if (!m || clr == 0) break;
         if (pas == maxp) begin
            ovf = 1'b1;
            break;
         end
      end
      gf = g;
   endfunction

   // One full run on both instances; lat_x counts rising edges from the last-row handshake
   // cycle until finished is seen.
   task automatic run(input logic [15:0] g, input bit m, input bit gaps, input bit poke,
                      output int lat_a, output int lat_b);
      int cyc;
      @(negedge clk);
      start = 1'b1;
      mode  = m;
      @(negedge clk);
      start = 1'b0;
      mode  = 1'b0;
      for (int r = 0; r < H; r++) begin
         if (gaps) begin
            load_valid = 1'b0;
            load_row   = 4'($urandom);
            chk("load_ready_in_load", int'(load_ready_a), 1);
            @(negedge clk);
         end
         load_valid = 1'b1;
         load_row   = g[r*W +: W];
         @(negedge clk);
      end
      load_valid = 1'b0;
      lat_a = -1;
      lat_b = -1;
      cyc   = 1;
      while ((lat_a < 0 || lat_b < 0) && cyc < 300) begin
         if (finished_a && lat_a < 0) lat_a = cyc;
         if (finished_b && lat_b < 0) lat_b = cyc;
         if (poke) begin
            // A start in the middle of the sweep must be ignored.
            start = (cyc == 3);
            mode  = 1'b1;
         end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      mode  = 1'b0;
      if (lat_a < 0 || lat_b < 0) chk("finish_timeout", cyc, -1);
   endtask

   task automatic check_run(input string tag, input logic [15:0] g, input bit m,
                            input bit gaps, input bit poke,
                            input int ra, input int pa, input int oa,
                            input int rb, input int pb, input int ob);
      int lat_a, lat_b, d_res, d_pas;
      bit d_ovf;
      logic [15:0] gf_a, gf_b;
      model(g, m, 255, d_res, d_pas, d_ovf, gf_a);
      model(g, m, 2,   d_res, d_pas, d_ovf, gf_b);
      run(g, m, gaps, poke, lat_a, lat_b);
      chk({tag, "_result_a"},   int'(result_a),   ra);
      chk({tag, "_passes_a"},   int'(passes_a),   pa);
      chk({tag, "_overflow_a"}, int'(overflow_a), oa);
      chk({tag, "_latency_a"},  lat_a,            pa * (H + 1) + 1);
      chk({tag, "_result_b"},   int'(result_b),   rb);
      chk({tag, "_passes_b"},   int'(passes_b),   pb);
      chk({tag, "_overflow_b"}, int'(overflow_b), ob);
      chk({tag, "_latency_b"},  lat_b,            pb * (H + 1) + 1);
      for (int r = 0; r < H; r++) begin
         chk($sformatf("%s_grid_a_row%0d", tag, r), int'(dut_a.grid[r]), int'(gf_a[r*W +: W]));
         chk($sformatf("%s_grid_b_row%0d", tag, r), int'(dut_b.grid[r]), int'(gf_b[r*W +: W]));
      end
   endtask

   typedef struct {
      string       name;
      logic [15:0] g;
      bit          m;
      bit          gaps;
      bit          poke;
      int          ra, pa, oa;
      int          rb, pb, ob;
   } vec_t;

   vec_t tbl [7];

   initial begin
      int rr, rp, rb2, rpb;
      bit ro, rob;
      logic [15:0] rg, rgf;
      bit rm, rgap;

      // Expected values worked out by hand from the erosion rules (A: MAX 255, B: MAX 2).
      tbl[0] = '{"empty_m1",     16'h0000, 1'b1, 1'b0, 1'b0, 0, 1, 0, 0, 1, 0};
      tbl[1] = '{"diag_m0",      16'h8421, 1'b0, 1'b0, 1'b0, 4, 1, 0, 4, 1, 0};
      tbl[2] = '{"diag_m1",      16'h8421, 1'b1, 1'b0, 1'b0, 4, 2, 0, 4, 2, 0};
      tbl[3] = '{"block_m0",     16'h0777, 1'b0, 1'b0, 1'b0, 4, 1, 0, 4, 1, 0};
      tbl[4] = '{"block_m1",     16'h0777, 1'b1, 1'b0, 1'b0, 9, 4, 0, 8, 2, 1};
      tbl[5] = '{"full_gap_m0",  16'hFFFF, 1'b0, 1'b1, 1'b1, 4, 1, 0, 4, 1, 0};
      tbl[6] = '{"full_gap_m1",  16'hFFFF, 1'b1, 1'b1, 1'b0, 4, 2, 0, 4, 2, 0};

      rst        = 1'b1;
      start      = 1'b0;
      mode       = 1'b0;
      load_valid = 1'b0;
      load_row   = 4'h0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("reset_busy",       int'(busy_a),       0);
      chk("reset_finished",   int'(finished_a),   0);
      chk("reset_load_ready", int'(load_ready_a), 0);
      chk("reset_result",     int'(result_a),     0);
      chk("reset_passes",     int'(passes_a),     0);
      chk("reset_overflow",   int'(overflow_a),   0);
      chk("reset_busy_b",     int'(busy_b | load_ready_b | finished_b), 0);

      for (int i = 0; i < 7; i++) begin
         check_run(tbl[i].name, tbl[i].g, tbl[i].m, tbl[i].gaps, tbl[i].poke,
                   tbl[i].ra, tbl[i].pa, tbl[i].oa, tbl[i].rb, tbl[i].pb, tbl[i].ob);
      end

      for (int i = 0; i < 16; i++) begin
         rg = 16'($urandom);
         if (i % 2 == 1) rg = rg | 16'($urandom);
         rm   = 1'($urandom_range(0, 1));
         rgap = 1'($urandom_range(0, 1));
         model(rg, rm, 255, rr,  rp,  ro,  rgf);
         model(rg, rm, 2,   rb2, rpb, rob, rgf);
         check_run($sformatf("rand%0d", i), rg, rm, rgap, 1'b0,
                   rr, rp, int'(ro), rb2, rpb, int'(rob));
      end

      // Reset on SWEEP cycle 2, with a start pulse in the same cycle.
      @(negedge clk);
      start = 1'b1;
      mode  = 1'b0;
      @(negedge clk);
      start = 1'b0;
      for (int r = 0; r < H; r++) begin
         load_valid = 1'b1;
         load_row   = (r < 3) ? 4'h7 : 4'h0;
         @(negedge clk);
      end
      load_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      // Rows 0 and 1 are done: the two top corners are cleared.
      chk("mid_sweep_result", int'(result_a), 2);
      rst   = 1'b1;
      start = 1'b1;
      @(negedge clk);
      rst   = 1'b0;
      start = 1'b0;
      chk("rst_sweep_busy",       int'(busy_a),       0);
      chk("rst_sweep_finished",   int'(finished_a),   0);
      chk("rst_sweep_result",     int'(result_a),     0);
      chk("rst_sweep_load_ready", int'(load_ready_a), 0);
      chk("rst_sweep_passes",     int'(passes_a),     0);
      @(negedge clk);
      chk("rst_start_ignored",    int'(busy_a),       0);
      check_run("after_rst", 16'h0777, 1'b0, 1'b0, 1'b0, 4, 1, 0, 4, 1, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, errors=%0d", n_err);
      $fatal(1);
   end

endmodule
